// File: rtl/seq_stim_tx_pkg.sv
// seq_tx_pkg -- shared types and constants for the seq_stim_tx block.
//   tx_state_t     : transmitter FSM states (IDLE, SHIFT, DONE)
//   RUN_LEN        : run length at which the detector asserts z
//   DEFAULT_WIDTH  : default pattern length in bits
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } tx_state_t;

    localparam int unsigned RUN_LEN       = 4;
    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_stim_tx_if.sv
// seq_stim_tx_if -- stimulus/serial bundle between the switch/key front end
// and the serial transmitter.
//   start, step, data : from the front end (master) to the transmitter
//   w, w_valid        : serial bit and its one-cycle "new bit" strobe
//   busy, done        : burst status
//   bit_idx           : bits emitted so far in the burst (hex display)
//   z_exp             : expected detector output for the bit on w
// modports: master (front end / testbench), slave (transmitter)
interface seq_stim_tx_if
    import seq_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             step;
    logic [WIDTH-1:0] data;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;
    logic [3:0]       bit_idx;
    logic             z_exp;

    modport master (
        output start, step, data,
        input  w, w_valid, busy, done, bit_idx, z_exp
    );

    modport slave (
        input  start, step, data,
        output w, w_valid, busy, done, bit_idx, z_exp
    );

endinterface

// File: rtl/seq_stim_tx_edge_detect.sv
// edge_detect -- one-register-deep rising-edge detector.
//   clk, reset : clock and synchronous active-high reset
//   in         : level input
//   rise       : high for the cycle in which in is 1 and was 0 at the last edge
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/seq_stim_tx.sv
// seq_stim_tx -- serial stimulus transmitter for the sequence-detector lab.
// Captures a WIDTH-bit pattern on a start edge and emits it MSB-first on w,
// one bit per step edge.
//   clk, reset : clock and synchronous active-high reset
//   bus        : seq_stim_tx_if.slave (start/step/data in; w, w_valid, busy,
//                done, bit_idx, z_exp out)
// Build option: define SEQ_TX_EXPECT_EN to compile in the run counter that
// produces z_exp (asserted when the current bit completes a run of RUN_LEN
// equal bits); otherwise z_exp is tied low.
module seq_stim_tx
    import seq_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    seq_stim_tx_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

    tx_state_t        state, state_nxt;
    logic             start_rise, step_rise;
    logic             take_start, take_step;
    logic [WIDTH-1:0] shreg;
    logic [3:0]       bit_idx;
    logic             w_q;
    logic             w_valid_q;
    logic             z_q;

    edge_detect u_start_ed (
        .clk   (clk),
        .reset (reset),
        .in    (bus.start),
        .rise  (start_rise)
    );

    edge_detect u_step_ed (
        .clk   (clk),
        .reset (reset),
        .in    (bus.step),
        .rise  (step_rise)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (step_rise && (bit_idx == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode. A start edge outside SHIFT wins over a
    // simultaneous step edge because steps are only honoured in SHIFT.
    always_comb begin
        take_start = 1'b0;
        take_step  = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (state)
            IDLE: begin
                take_start = start_rise;
            end
            SHIFT: begin
                take_step = step_rise;
                bus.busy  = 1'b1;
            end
            DONE: begin
                take_start = start_rise;
                bus.done   = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            bit_idx   <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
        end else begin
            w_valid_q <= 1'b0;
            if (take_start) begin
                shreg   <= bus.data;
                bit_idx <= '0;
                w_q     <= 1'b0;
            end else if (take_step) begin
                w_q       <= shreg[WIDTH-1];
                shreg     <= shreg << 1;
                bit_idx   <= bit_idx + 4'd1;
                w_valid_q <= 1'b1;
            end
        end
    end

`ifdef SEQ_TX_EXPECT_EN
    logic [2:0] run;
    logic [2:0] run_nxt;

    // Previous emitted bit is still on w_q; bit_idx == 0 marks the first
    // bit of a burst, so stale w from an earlier burst never extends a run.
    always_comb begin
        run_nxt = run;
        if ((bit_idx == 4'd0) || (shreg[WIDTH-1] != w_q)) begin
            run_nxt = 3'd1;
        end else if (run >= 3'(RUN_LEN)) begin
            run_nxt = 3'(RUN_LEN);
        end else begin
            run_nxt = run + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run <= '0;
            z_q <= 1'b0;
        end else if (take_start) begin
            run <= '0;
            z_q <= 1'b0;
        end else if (take_step) begin
            run <= run_nxt;
            z_q <= (run_nxt == 3'(RUN_LEN));
        end
    end
`else
    assign z_q = 1'b0;
`endif

    assign bus.w       = w_q;
    assign bus.w_valid = w_valid_q;
    assign bus.bit_idx = bit_idx;
    assign bus.z_exp   = z_q;

endmodule

// File: tb/tb_seq_stim_tx.sv
// tb_seq_stim_tx -- directed self-checking bench for seq_stim_tx (WIDTH = 8).
// Expected z_exp values depend on whether SEQ_TX_EXPECT_EN is defined.
module tb_seq_stim_tx;
    import seq_tx_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   passes;
    int   fails;
    int   vcount;
    int   vbase;

    seq_stim_tx_if #(.WIDTH(8)) bus ();

    seq_stim_tx #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.w_valid === 1'b1) vcount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".w"},       32'(bus.w),       0);
        check({tag, ".w_valid"}, 32'(bus.w_valid), 0);
        check({tag, ".busy"},    32'(bus.busy),    0);
        check({tag, ".done"},    32'(bus.done),    0);
        check({tag, ".bit_idx"}, 32'(bus.bit_idx), 0);
        check({tag, ".z_exp"},   32'(bus.z_exp),   0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] d);
        bus.data  = d;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Emits n bits; wv/zv hold the expected bits MSB-first.
    task automatic emit_bits(input logic [7:0] wv, input logic [7:0] zv,
                             input int n, input int idx0);
        logic ze;
        for (int i = 0; i < n; i++) begin
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
`ifdef SEQ_TX_EXPECT_EN
            ze = zv[7-i];
`else
            ze = 1'b0;
`endif
            check($sformatf("w[%0d]", idx0 + i),       32'(bus.w),       32'(wv[7-i]));
            check($sformatf("z_exp[%0d]", idx0 + i),   32'(bus.z_exp),   32'(ze));
            check($sformatf("bit_idx[%0d]", idx0 + i), 32'(bus.bit_idx), 32'(idx0 + i + 1));
            check($sformatf("w_valid[%0d]", idx0 + i), 32'(bus.w_valid), 1);
            tick();
            check($sformatf("w_valid_off[%0d]", idx0 + i), 32'(bus.w_valid), 0);
        end
    endtask

    initial begin
        total = 0; passes = 0; fails = 0; vcount = 0;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        bus.data  = '0;
        reset     = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Burst of F0
        pulse_start(8'hF0);
        check("f0.busy", 32'(bus.busy), 1);
        check("f0.bit_idx0", 32'(bus.bit_idx), 0);
        emit_bits(8'b1111_0000, 8'b0001_0001, 8, 0);
        check("f0.done", 32'(bus.done), 1);
        check("f0.busy_end", 32'(bus.busy), 0);
        check("f0.bit_idx8", 32'(bus.bit_idx), 8);

        // Step in DONE is ignored
        vbase = vcount;
        bus.step = 1'b1; tick(); bus.step = 1'b0; tick();
        check("done_step.w", 32'(bus.w), 0);
        check("done_step.bit_idx", 32'(bus.bit_idx), 8);
        check("done_step.vcount", vcount - vbase, 0);
        check("done_step.done", 32'(bus.done), 1);

        // Burst of A5 from DONE
        vbase = vcount;
        pulse_start(8'hA5);
        check("a5.done_clr", 32'(bus.done), 0);
        check("a5.w_clr", 32'(bus.w), 0);
        emit_bits(8'hA5, 8'h00, 8, 0);
        check("a5.pulses", vcount - vbase, 8);
        check("a5.done", 32'(bus.done), 1);

        // Held start and step levels count once each
        vbase = vcount;
        bus.data  = 8'h80;
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.start = 1'b0;
        check("held.busy", 32'(bus.busy), 1);
        check("held.bit_idx0", 32'(bus.bit_idx), 0);
        bus.step = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.step = 1'b0;
        tick();
        check("held.bit_idx1", 32'(bus.bit_idx), 1);
        check("held.pulses", vcount - vbase, 1);
        check("held.w", 32'(bus.w), 1);

        // Reset mid-burst discards everything
        do_reset();
        check_idle_outputs("midreset");

        // Start during SHIFT ignored
        pulse_start(8'hF0);
        emit_bits(8'b1110_0000, 8'b0000_0000, 3, 0);
        pulse_start(8'h00);
        check("ign.busy", 32'(bus.busy), 1);
        check("ign.bit_idx", 32'(bus.bit_idx), 3);
        emit_bits(8'b1000_0000, 8'b1000_1000, 5, 3);
        check("ign.done", 32'(bus.done), 1);

        // Reset after 3 bits, then a fresh pattern
        pulse_start(8'hF0);
        emit_bits(8'b1110_0000, 8'b0000_0000, 3, 0);
        do_reset();
        check_idle_outputs("rst3");
        pulse_start(8'h3C);
        emit_bits(8'h3C, 8'b0000_0100, 8, 0);
        check("3c.done", 32'(bus.done), 1);

        // Simultaneous start and step edges in IDLE
        do_reset();
        vbase = vcount;
        bus.data  = 8'hFF;
        bus.start = 1'b1;
        bus.step  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.step  = 1'b0;
        check("same.busy", 32'(bus.busy), 1);
        check("same.bit_idx", 32'(bus.bit_idx), 0);
        check("same.w_valid", 32'(bus.w_valid), 0);
        tick();
        check("same.pulses", vcount - vbase, 0);
        emit_bits(8'b1000_0000, 8'b0000_0000, 1, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
